// File: rtl/eth_tx_sched_if.sv
// eth_tx_sched_if: groups the two requester channels and the eth_send engine
// channel of the transmit scheduler.
//   master : scheduler side (drives grant, header, strobes, done/err, tx_en)
//   slave  : environment side (requesters and frame engine)
interface eth_tx_sched_if;
    localparam int unsigned MAC_W  = 48;
    localparam int unsigned TYPE_W = 16;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned DATA_W = 8;

    // requester 0
    logic              req0;
    logic [MAC_W-1:0]  mac0;
    logic [TYPE_W-1:0] type0;
    logic [LEN_W-1:0]  len0;
    logic              rdreq0;
    logic [DATA_W-1:0] data0;
    logic              done0;
    // requester 1
    logic              req1;
    logic [MAC_W-1:0]  mac1;
    logic [TYPE_W-1:0] type1;
    logic [LEN_W-1:0]  len1;
    logic              rdreq1;
    logic [DATA_W-1:0] data1;
    logic              done1;
    // shared status
    logic              err;
    logic              grant;
    // frame engine
    logic              tx_en;
    logic [MAC_W-1:0]  target_mac_addr;
    logic [TYPE_W-1:0] frame_type;
    logic [LEN_W-1:0]  fifo_data_length;
    logic              fifo_rdreq;
    logic [DATA_W-1:0] fifo_data;
    logic              gmii_tx_en;

    modport master (
        input  req0, mac0, type0, len0, data0,
        input  req1, mac1, type1, len1, data1,
        input  fifo_rdreq, gmii_tx_en,
        output rdreq0, done0, rdreq1, done1, err, grant,
        output tx_en, target_mac_addr, frame_type, fifo_data_length, fifo_data
    );

    modport slave (
        output req0, mac0, type0, len0, data0,
        output req1, mac1, type1, len1, data1,
        output fifo_rdreq, gmii_tx_en,
        input  rdreq0, done0, rdreq1, done1, err, grant,
        input  tx_en, target_mac_addr, frame_type, fifo_data_length, fifo_data
    );
endinterface

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: two-requester transmit scheduler in front of the eth_send
// frame engine (GMII tx clock domain). Arbitrates, latches the winner's
// header, fires tx_en, steers payload strobe/data, pads short payloads with
// zeros, rejects oversize frames, times out a silent engine and enforces
// the inter-frame gap.
// Ports:
//   gmii_tx_clk : sole clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : eth_tx_sched_if.master (requesters + engine channel)
// Build option: define ETH_TX_SCHED_RR_EN for round-robin arbitration;
// otherwise fixed priority with requester 0 winning.
module eth_tx_sched #(
    parameter int unsigned IFG_CYCLES    = 12,
    parameter int unsigned START_TIMEOUT = 64,
    parameter int unsigned MIN_PAYLOAD   = 46,
    parameter int unsigned MAX_PAYLOAD   = 1500
) (
    input logic            gmii_tx_clk,
    input logic            rst_n,
    eth_tx_sched_if.master bus
);
    localparam int unsigned MAC_W  = 48;
    localparam int unsigned TYPE_W = 16;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_START,
        S_WAIT_TX,
        S_BUSY,
        S_IFG
    } state_e;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic [MAC_W-1:0]  mac_q, mac_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  flen_q, flen_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic              tx_en_q, tx_en_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              err_q, err_d;
    logic              gmii_q;

    logic req0_eff, req1_eff, win;
    logic tx_rise, tx_fall;
    logic in_payload;

    // A request whose done is pulsing this cycle is the one just finished.
    assign req0_eff = bus.req0 & ~done0_q;
    assign req1_eff = bus.req1 & ~done1_q;

    assign tx_rise = bus.gmii_tx_en & ~gmii_q;
    assign tx_fall = ~bus.gmii_tx_en & gmii_q;

`ifdef ETH_TX_SCHED_RR_EN
    logic last_q;

    // On a tie the source not served last wins; reset value 1 favours source 0.
    assign win = (req0_eff && req1_eff) ? ~last_q : req1_eff;

    // Last-served flag, updated at every grant.
    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (state_q == S_IDLE && (req0_eff || req1_eff)) begin
            last_q <= win;
        end
    end
`else
    assign win = ~req0_eff;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        mac_d   = mac_q;
        type_d  = type_q;
        len_d   = len_q;
        flen_d  = flen_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        tx_en_d = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0_eff || req1_eff) begin
                    grant_d = win;
                    mac_d   = win ? bus.mac1  : bus.mac0;
                    type_d  = win ? bus.type1 : bus.type0;
                    len_d   = win ? bus.len1  : bus.len0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (len_q > LEN_W'(MAX_PAYLOAD)) begin
                    done0_d = ~grant_q;
                    done1_d = grant_q;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    flen_d  = (len_q < LEN_W'(MIN_PAYLOAD)) ? LEN_W'(MIN_PAYLOAD) : len_q;
                    tx_en_d = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                beat_d  = '0;
                cnt_d   = '0;
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (tx_rise) begin
                    state_d = S_BUSY;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    done0_d = ~grant_q;
                    done1_d = grant_q;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IFG;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BUSY: begin
                if (bus.fifo_rdreq && beat_q != '1) begin
                    beat_d = beat_q + CNT_W'(1);
                end
                if (tx_fall) begin
                    done0_d = ~grant_q;
                    done1_d = grant_q;
                    cnt_d   = '0;
                    state_d = S_IFG;
                end
            end
            S_IFG: begin
                if (cnt_q == CNT_W'(IFG_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            mac_q   <= '0;
            type_q  <= '0;
            len_q   <= '0;
            flen_q  <= '0;
            cnt_q   <= '0;
            beat_q  <= '0;
            tx_en_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            gmii_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            mac_q   <= mac_d;
            type_q  <= type_d;
            len_q   <= len_d;
            flen_q  <= flen_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            tx_en_q <= tx_en_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err_q   <= err_d;
            gmii_q  <= bus.gmii_tx_en;
        end
    end

    // Same-cycle payload steering; beats past the real length are zero padding.
    assign in_payload    = (state_q == S_BUSY) && (beat_q < len_q);
    assign bus.rdreq0    = in_payload & ~grant_q & bus.fifo_rdreq;
    assign bus.rdreq1    = in_payload &  grant_q & bus.fifo_rdreq;
    assign bus.fifo_data = in_payload ? (grant_q ? bus.data1 : bus.data0) : 8'h00;

    assign bus.tx_en            = tx_en_q;
    assign bus.done0            = done0_q;
    assign bus.done1            = done1_q;
    assign bus.err              = err_q;
    assign bus.grant            = grant_q;
    assign bus.target_mac_addr  = mac_q;
    assign bus.frame_type       = type_q;
    assign bus.fifo_data_length = flen_q;
endmodule

// File: doc/eth_tx_sched.md
# eth_tx_sched

Two-requester transmit scheduler in front of the `eth_send` frame engine on the GMII transmit clock domain. Arbitrates between two frame sources (e.g. ARP responder and UDP payload path) and latches the granted source's header fields. Fires the engine's one-cycle `tx_en` start pulse and steers the engine's payload read strobe and data between the engine and the granted source. Enforces minimum-payload zero padding, oversize rejection, a start timeout and the inter-frame gap.

## Interface
- `IFG_CYCLES`, 12: idle cycles inserted after `gmii_tx_en` falls before the next grant.
- `START_TIMEOUT`, 64: cycles allowed from `tx_en` pulse to `gmii_tx_en` rising.
- `MIN_PAYLOAD`, 46: minimum payload length passed to the engine.
- `MAX_PAYLOAD`, 1500: largest accepted requester length.

Ports:
- `gmii_tx_clk` in 1: sole clock, all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0`, `req1` in 1: level request; held until the matching `done` pulse.
- `mac0`, `mac1` in 48: target MAC, sampled at grant.
- `type0`, `type1` in 16: frame type, sampled at grant.
- `len0`, `len1` in 16: payload byte count, sampled at grant.
- `rdreq0`, `rdreq1` out 1: payload read strobe to the source.
- `data0`, `data1` in 8: source payload byte, valid in the same cycle as its `rdreq`.
- `done0`, `done1` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse, qualifies `doneN` as failed (oversize or timeout).
- `tx_en` out 1: one-cycle start pulse to the engine.
- `target_mac_addr` out 48, `frame_type` out 16, `fifo_data_length` out 16: latched header fields to the engine.
- `fifo_rdreq` in 1: engine payload read strobe.
- `fifo_data` out 8: payload byte to the engine.
- `gmii_tx_en` in 1: engine transmit enable, monitored for frame start and end.
- `grant` out 1: index of the current or last granted source.

## Operation
- States: IDLE, CHECK, START, WAIT_TX, BUSY, IFG.
- IDLE, any `reqN` high: select a winner (see Configuration), latch its mac/type/len and set `grant`, then go to CHECK.
- CHECK: latched len > MAX_PAYLOAD pulses `doneN` and `err` together and returns to IDLE; no `tx_en` is issued. Otherwise `fifo_data_length` = max(len, MIN_PAYLOAD) and go to START.
- START: `tx_en` = 1 for exactly this cycle. Clear the beat counter and go to WAIT_TX.
- WAIT_TX: `gmii_tx_en` rising goes to BUSY. After START_TIMEOUT cycles without a rise, pulse `doneN` and `err` and go to IFG.
- BUSY: `rdreq<grant>` = `fifo_rdreq`; the other `rdreq` stays 0.
  - `fifo_data` = `data<grant>` while beat count < latched len, else 8'h00 (padding; no `rdreq` is forwarded to the source for padding beats).
  - The 16-bit beat counter increments on each `fifo_rdreq` and saturates at 16'hFFFF.
  - `gmii_tx_en` falling pulses `doneN` (with `err` = 0) and goes to IFG.
- IFG: count IFG_CYCLES cycles, then go to IDLE. A request arriving during IFG waits.
- Outside BUSY: both `rdreq` = 0 and `fifo_data` = 8'h00.
- Header outputs hold their latched values from grant until the next grant.

## Timing
- Reset values: state IDLE; `tx_en`, `rdreq0/1`, `done0/1`, `err` = 0; `grant` = 0; `fifo_data` = 0; `target_mac_addr`, `frame_type`, `fifo_data_length` = 0; counters = 0.
- Request to `tx_en`: 2 cycles (IDLE then CHECK, `tx_en` asserted in the third cycle).
- `rdreq`/`fifo_data` steering is combinational: zero-latency pass-through, matching the engine's same-cycle data expectation.
- `doneN` is registered and asserted in the cycle after `gmii_tx_en` is sampled low.
- Minimum spacing from `gmii_tx_en` fall to the next `tx_en` is IFG_CYCLES + 3 cycles.
- `reqN` dropped mid-frame: ignored; the frame completes and `doneN` still pulses.
- Reset mid-frame: immediate return to IDLE with outputs at reset values; the engine is not notified.
- Both requests rising in the same cycle: resolved by the arbitration rule; the loser waits without loss.

## Configuration
- `ETH_TX_SCHED_RR_EN` defined: round-robin arbitration. A last-served flag, reset to 1, makes source 0 win the first tie. It updates at every grant, including grants that end in an error.
- Not defined: fixed priority, `req0` always wins. The last-served flag is not implemented.

## Test plan
- `req0` alone, len0 = 28, engine asserts `gmii_tx_en` 8 cycles after `tx_en` -> `tx_en` 2 cycles after `req0`; `fifo_data_length` = 46; `rdreq0` 28 beats; beats 28–45 present 8'h00; one `done0` with `err` = 0.
- `req1` alone, len1 = 1501 -> no `tx_en`; `done1` and `err` pulse together 2 cycles after request.
- Engine never raises `gmii_tx_en` -> `done0` and `err` exactly START_TIMEOUT cycles after WAIT_TX entry; then an IFG of 12 cycles.
- `req0` and `req1` held high together for 3 frames -> RR build: grants 0,1,0; non-RR build: grants 0,0,0. Next `tx_en` ≥ 15 cycles after each `gmii_tx_en` fall.
- `rst_n` pulsed low during BUSY at beat 10 -> all outputs 0 in the same cycle; a new `req1` after release is granted normally.
- len0 = 60, `type0` = 16'h0806, `mac0` = 48'hFFFFFFFFFFFF, `mac0` changed mid-frame -> `target_mac_addr` stays FFFFFFFFFFFF; `fifo_data_length` = 60; no padding beats.
